inertial_fuser: RTL and testbench

INERTIAL_FUSER -- requirements
Module: inertial_fuser

---
 rtl/inertial_fuser.sv | 164 ++++++++++++++++
 tb/tb_inertial_fuser.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inertial_fuser.sv
// Complementary pitch filter: integrates offset-corrected gyro rate and nudges the
// integral toward an accel-derived pitch, with an averaging offset calibrator.
module inertial_fuser #(
    parameter int                DATA_W      = 16,
    parameter int                INT_W       = 27,
    parameter logic [DATA_W-1:0] RT_OFF_DFLT = 16'h0050,
    parameter logic [DATA_W-1:0] AZ_OFF_DFLT = 16'h00A0,
    parameter int                ACC_GAIN    = 327,
    parameter int                ACC_SHIFT   = 13,
    parameter int                FUSION_STEP = 1024,
    parameter int                CAL_LOG2    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld,
    input  logic signed [DATA_W-1:0] ptch_rt,
    input  logic signed [DATA_W-1:0] AZ,
    input  logic                     cal_req,
    output logic signed [DATA_W-1:0] ptch,
    output logic                     ptch_vld,
    output logic                     cal_busy,
    output logic                     cal_done,
    output logic        [DATA_W-1:0] rt_off,
    output logic        [DATA_W-1:0] az_off
);

    localparam int ACC_W  = DATA_W + CAL_LOG2;
    localparam int CNT_W  = CAL_LOG2 + 1;
    localparam int SUM_W  = INT_W + 2;
    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DIFF_W + 32;

    localparam logic        [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);
    localparam logic signed [PROD_W-1:0] GAIN_S   = PROD_W'(ACC_GAIN);
    localparam logic signed [SUM_W-1:0]  STEP_S   = SUM_W'(FUSION_STEP);
    localparam logic signed [INT_W-1:0]  INT_MAX  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0]  INT_MIN  = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic {
        RUN = 1'b0,
        CAL = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic signed [INT_W-1:0]  ptch_int_q, ptch_int_d;
    logic        [DATA_W-1:0] rt_off_q, rt_off_d;
    logic        [DATA_W-1:0] az_off_q, az_off_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_rt_q, acc_rt_d;
    logic signed [ACC_W-1:0]  acc_az_q, acc_az_d;
    logic                     ptch_vld_q, ptch_vld_d;
    logic                     cal_done_q, cal_done_d;

    logic signed [DIFF_W-1:0] rt_c;
    logic signed [DIFF_W-1:0] az_c;
    logic signed [PROD_W-1:0] acc_prod;
    logic signed [DATA_W-1:0] ptch_acc;
    logic signed [SUM_W-1:0]  fusion;
    logic signed [SUM_W-1:0]  int_sum;
    logic signed [INT_W-1:0]  int_sat;
    logic signed [ACC_W-1:0]  acc_rt_nxt;
    logic signed [ACC_W-1:0]  acc_az_nxt;

    assign ptch     = ptch_int_q[INT_W-1 -: DATA_W];
    assign ptch_vld = ptch_vld_q;
    assign cal_busy = (state_q == CAL);
    assign cal_done = cal_done_q;
    assign rt_off   = rt_off_q;
    assign az_off   = az_off_q;

    // Offset subtraction is one bit wider than the samples so it never wraps.
    always_comb begin
        rt_c     = DIFF_W'(ptch_rt) - DIFF_W'($signed(rt_off_q));
        az_c     = DIFF_W'(AZ) - DIFF_W'($signed(az_off_q));
        acc_prod = PROD_W'(az_c) * GAIN_S;
        ptch_acc = DATA_W'(acc_prod >>> ACC_SHIFT);
        fusion   = (ptch_acc > ptch) ? STEP_S : -STEP_S;
        int_sum  = SUM_W'(ptch_int_q) - SUM_W'(rt_c) + fusion;

        // The guard bits must all match the sign bit for the sum to fit in INT_W.
        if (int_sum[SUM_W-1:INT_W-1] == {(SUM_W-INT_W+1){int_sum[SUM_W-1]}}) begin
            int_sat = int_sum[INT_W-1:0];
        end else if (int_sum[SUM_W-1]) begin
            int_sat = INT_MIN;
        end else begin
            int_sat = INT_MAX;
        end

        acc_rt_nxt = acc_rt_q + ACC_W'(ptch_rt);
        acc_az_nxt = acc_az_q + ACC_W'(AZ);
    end

    always_comb begin
        state_d    = state_q;
        ptch_int_d = ptch_int_q;
        rt_off_d   = rt_off_q;
        az_off_d   = az_off_q;
        cnt_d      = cnt_q;
        acc_rt_d   = acc_rt_q;
        acc_az_d   = acc_az_q;
        ptch_vld_d = 1'b0;
        cal_done_d = 1'b0;

        unique case (state_q)
            RUN: begin
                if (vld) begin
                    ptch_int_d = int_sat;
                    ptch_vld_d = 1'b1;
                end
                // A sample arriving with the request is integrated, not averaged.
                if (cal_req) begin
                    state_d  = CAL;
                    cnt_d    = '0;
                    acc_rt_d = '0;
                    acc_az_d = '0;
                end
            end
            CAL: begin
                if (vld) begin
                    if (cnt_q == CNT_LAST) begin
                        rt_off_d   = DATA_W'(acc_rt_nxt >>> CAL_LOG2);
                        az_off_d   = DATA_W'(acc_az_nxt >>> CAL_LOG2);
                        ptch_int_d = '0;
                        cal_done_d = 1'b1;
                        state_d    = RUN;
                        cnt_d      = '0;
                        acc_rt_d   = '0;
                        acc_az_d   = '0;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        acc_rt_d = acc_rt_nxt;
                        acc_az_d = acc_az_nxt;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ptch_int_q <= '0;
            rt_off_q   <= RT_OFF_DFLT;
            az_off_q   <= AZ_OFF_DFLT;
            cnt_q      <= '0;
            acc_rt_q   <= '0;
            acc_az_q   <= '0;
            ptch_vld_q <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptch_int_q <= ptch_int_d;
            rt_off_q   <= rt_off_d;
            az_off_q   <= az_off_d;
            cnt_q      <= cnt_d;
            acc_rt_q   <= acc_rt_d;
            acc_az_q   <= acc_az_d;
            ptch_vld_q <= ptch_vld_d;
            cal_done_q <= cal_done_d;
        end
    end

endmodule

// File: tb/tb_inertial_fuser.sv
// Directed and randomized bench for inertial_fuser against an arithmetic reference
// model of the pitch filter and its sample-averaging calibrator.
module tb_inertial_fuser;

    localparam longint M_INT_MAX = 67108863;
    localparam longint M_INT_MIN = -67108864;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [15:0] ptch_rt_i;
    logic [15:0] az_i;
    logic        cal_req;
    logic [15:0] ptch;
    logic        ptch_vld;
    logic        cal_busy;
    logic        cal_done;
    logic [15:0] rt_off;
    logic [15:0] az_off;

    int     n_checks = 0;
    int     n_errors = 0;
    string  phase = "reset";

    longint m_int;
    int     m_rt_off;
    int     m_az_off;
    bit     m_cal;
    bit     exp_pv;
    bit     exp_cd;
    int     cal_rt_q[$];
    int     cal_az_q[$];

    always #5 clk = ~clk;

    inertial_fuser dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .ptch_rt (ptch_rt_i),
        .AZ      (az_i),
        .cal_req (cal_req),
        .ptch    (ptch),
        .ptch_vld(ptch_vld),
        .cal_busy(cal_busy),
        .cal_done(cal_done),
        .rt_off  (rt_off),
        .az_off  (az_off)
    );

    function automatic int sx16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic logic [15:0] u16(input longint v);
        return v[15:0];
    endfunction

    function automatic int model_ptch();
        return int'(m_int >>> 11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, expv);
        end
    endtask

    // Reference model: one call per clock edge, using the inputs seen at that edge.
    task automatic model_edge(input bit r, input bit v, input int rt, input int az, input bit cr);
        longint rt_c, az_c, fus, nxt, s_rt, s_az;
        int     a;
        exp_pv = 1'b0;
        exp_cd = 1'b0;
        if (r) begin
            m_int    = 0;
            m_rt_off = 'h50;
            m_az_off = 'hA0;
            m_cal    = 1'b0;
            cal_rt_q.delete();
            cal_az_q.delete();
        end else if (!m_cal) begin
            if (v) begin
                rt_c = longint'(rt) - m_rt_off;
                az_c = longint'(az) - m_az_off;
                a    = sx16((az_c * 327) >>> 13);
                fus  = (a > model_ptch()) ? 1024 : -1024;
                nxt  = m_int - rt_c + fus;
                if (nxt > M_INT_MAX) nxt = M_INT_MAX;
                if (nxt < M_INT_MIN) nxt = M_INT_MIN;
                m_int  = nxt;
                exp_pv = 1'b1;
            end
            if (cr) begin
                m_cal = 1'b1;
                cal_rt_q.delete();
                cal_az_q.delete();
            end
        end else if (v) begin
            cal_rt_q.push_back(rt);
            cal_az_q.push_back(az);
            if (cal_rt_q.size() == 16) begin
                s_rt = 0;
                s_az = 0;
                foreach (cal_rt_q[i]) s_rt += cal_rt_q[i];
                foreach (cal_az_q[i]) s_az += cal_az_q[i];
                m_rt_off = sx16(s_rt >>> 4);
                m_az_off = sx16(s_az >>> 4);
                m_int    = 0;
                m_cal    = 1'b0;
                exp_cd   = 1'b1;
                cal_rt_q.delete();
                cal_az_q.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("ptch",     32'(ptch),     32'(u16(longint'(model_ptch()))));
        chk("ptch_vld", 32'(ptch_vld), 32'(exp_pv));
        chk("cal_busy", 32'(cal_busy), 32'(m_cal));
        chk("cal_done", 32'(cal_done), 32'(exp_cd));
        chk("rt_off",   32'(rt_off),   32'(u16(longint'(m_rt_off))));
        chk("az_off",   32'(az_off),   32'(u16(longint'(m_az_off))));
    endtask

    // Drive one clock of inputs, advance the model, then sample just after the edge.
    task automatic step(input bit r, input bit v, input int rt, input int az, input bit cr);
        rst       = r;
        vld       = v;
        ptch_rt_i = 16'(rt);
        az_i      = 16'(az);
        cal_req   = cr;
        @(posedge clk);
        model_edge(r, v, rt, az, cr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        vld       = 1'b0;
        ptch_rt_i = '0;
        az_i      = '0;
        cal_req   = 1'b0;

        phase = "reset";
        step(1'b1, 1'b1, 'h50, 'hA0, 1'b1);
        chk("rst_ptch",   32'(ptch),   32'h0);
        chk("rst_rt_off", 32'(rt_off), 32'h50);
        chk("rst_az_off", 32'(az_off), 32'hA0);
        chk("rst_busy",   32'(cal_busy), 32'h0);
        step(1'b0, 1'b0, 0, 0, 1'b0);

        phase = "alternate";
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 'h50, 'hA0, 1'b0);
            chk("alt_ptch", 32'(ptch), (i % 2 == 0) ? 32'hFFFF : 32'h0);
            step(1'b0, 1'b0, 'h50, 'hA0, 1'b0);
            chk("alt_hold", 32'(ptch), (i % 2 == 0) ? 32'hFFFF : 32'h0);
        end

        phase = "rate_step";
        do_reset();
        step(1'b0, 1'b1, 'h850, 'hA0, 1'b0);
        chk("rate_v1", 32'(ptch), 32'hFFFE);
        step(1'b0, 1'b1, 'h850, 'hA0, 1'b0);
        chk("rate_v2", 32'(ptch), 32'hFFFE);

        phase = "saturate";
        do_reset();
        for (int i = 0; i < 2300; i++) begin
            step(1'b0, 1'b1, sx16('h8050), 'hA0, 1'b0);
        end
        chk("sat_top", 32'(ptch), 32'h7FFF);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("sat_vld_drop", 32'(ptch_vld), 32'h0);

        phase = "calibrate";
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 'h850, 'hA0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        chk("cal_enter", 32'(cal_busy), 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 'h60, 'hB0, (i == 4));
            if (i == 7) step(1'b0, 1'b0, 0, 0, 1'b0);
        end
        chk("cal_done_pulse", 32'(cal_done), 32'h1);
        chk("cal_rt_off",     32'(rt_off),   32'h60);
        chk("cal_az_off",     32'(az_off),   32'hB0);
        chk("cal_ptch_zero",  32'(ptch),     32'h0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("cal_done_once", 32'(cal_done), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 'h60, 'hB0, 1'b0);
            chk("cal_alt", 32'(ptch), (i % 2 == 0) ? 32'hFFFF : 32'h0);
        end

        phase = "cal_abort";
        do_reset();
        step(1'b0, 1'b1, 'h850, 'hA0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 'h60, 'hB0, 1'b0);
        step(1'b1, 1'b1, 'h60, 'hB0, 1'b0);
        chk("abort_busy",   32'(cal_busy), 32'h0);
        chk("abort_rt_off", 32'(rt_off),   32'h50);
        chk("abort_az_off", 32'(az_off),   32'hA0);
        chk("abort_ptch",   32'(ptch),     32'h0);
        chk("abort_done",   32'(cal_done), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);

        phase = "req_with_vld";
        do_reset();
        step(1'b0, 1'b1, 'h50, 'hA0, 1'b1);
        chk("rv_pvld", 32'(ptch_vld), 32'h1);
        chk("rv_busy", 32'(cal_busy), 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 'h58, 'hA8, 1'b0);
            if (i < 15) chk("rv_no_done", 32'(cal_done), 32'h0);
        end
        chk("rv_done", 32'(cal_done), 32'h1);
        chk("rv_rt_off", 32'(rt_off), 32'h58);

        phase = "random";
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int rt_r, az_r;
            if ($urandom_range(0, 1) == 0) begin
                rt_r = int'($urandom_range(0, 32000)) - 16000;
                az_r = int'($urandom_range(0, 32000)) - 16000;
            end else begin
                rt_r = m_rt_off + int'($urandom_range(0, 400)) - 200;
                az_r = m_az_off + int'($urandom_range(0, 4000)) - 2000;
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
                 rt_r, az_r, ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
